// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: pin conditioning, 11-bit frame deserialiser with
// parity/stop/timeout checks, and a first-word-fall-through scancode FIFO.
module ps2_rx_fifo #(
    parameter int FIFO_DEPTH     = 8,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 15000
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic                          ps2_clk_i,
    input  logic                          ps2_data_i,
    input  logic                          rd_en,
    output logic [7:0]                    rd_data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    input  logic                          err_clr,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    logic           clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
    logic           filt_clk_q, filt_clk_d;
    logic [FCW-1:0] filt_cnt_q, filt_cnt_d;
    logic           fall_q, fall_d;

    logic [1:0]     state_q, state_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           parity_q, parity_d;
    logic [TW-1:0]  timeout_q, timeout_d;

    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           parity_err_q, parity_err_d;
    logic           frame_err_q, frame_err_d;
    logic           overflow_q, overflow_d;

    logic [7:0]     mem [FIFO_DEPTH];

    logic           push, pop, wr_en, set_par, set_frm, set_ovf;

    // Filtered clock only follows the synchronised pin after FILTER_LEN stable cycles
    always_comb begin
        filt_clk_d = filt_clk_q;
        filt_cnt_d = '0;
        if (clk_sync_q != filt_clk_q) begin
            if (filt_cnt_q == FCW'(FILTER_LEN - 1)) begin
                filt_clk_d = clk_sync_q;
            end else begin
                filt_cnt_d = filt_cnt_q + FCW'(1);
            end
        end
        fall_d = filt_clk_q & ~filt_clk_d;
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        push      = 1'b0;
        set_par   = 1'b0;
        set_frm   = 1'b0;
        timeout_d = (state_q == ST_IDLE || fall_q) ? '0 : timeout_q + TW'(1);
        if (fall_q) begin
            case (state_q)
                ST_IDLE: begin
                    if (!data_sync_q) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                ST_DATA: begin
                    shift_d   = {data_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    parity_d = data_sync_q;
                    state_d  = ST_STOP;
                end
                default: begin
                    state_d = ST_IDLE;
                    set_par = ~(^{shift_q, parity_q});
                    set_frm = ~data_sync_q;
                    push    = data_sync_q & (^{shift_q, parity_q});
                end
            endcase
        end else if (state_q != ST_IDLE && timeout_q == TW'(TIMEOUT_CYCLES)) begin
            // Device went quiet mid-frame: drop the partial frame
            state_d   = ST_IDLE;
            set_frm   = 1'b1;
            timeout_d = '0;
        end
    end

    // A push into a full FIFO still lands if the head leaves in the same cycle
    always_comb begin
        pop          = rd_en && (count_q != '0);
        wr_en        = push && (!full || pop);
        set_ovf      = push && full && !pop;
        wr_ptr_d     = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d     = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d      = count_q + CW'(wr_en) - CW'(pop);
        parity_err_d = (parity_err_q & ~err_clr) | set_par;
        frame_err_d  = (frame_err_q & ~err_clr) | set_frm;
        overflow_d   = (overflow_q & ~err_clr) | set_ovf;
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            clk_meta_q   <= 1'b1;
            clk_sync_q   <= 1'b1;
            data_meta_q  <= 1'b1;
            data_sync_q  <= 1'b1;
            filt_clk_q   <= 1'b1;
            filt_cnt_q   <= '0;
            fall_q       <= 1'b0;
            state_q      <= ST_IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            parity_q     <= 1'b0;
            timeout_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            clk_meta_q   <= ps2_clk_i;
            clk_sync_q   <= clk_meta_q;
            data_meta_q  <= ps2_data_i;
            data_sync_q  <= data_meta_q;
            filt_clk_q   <= filt_clk_d;
            filt_cnt_q   <= filt_cnt_d;
            fall_q       <= fall_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            timeout_q    <= timeout_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overflow_q   <= overflow_d;
        end
    end

    always_ff @(posedge ACLK) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= shift_q;
        end
    end

    assign empty      = (count_q == '0);
    assign full       = (count_q == CW'(FIFO_DEPTH));
    assign count      = count_q;
    assign rd_data    = empty ? 8'h00 : mem[rd_ptr_q];
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
- PS/2 keyboard receive front end that feeds the AXI 7-seg/PS2 register file.
- Synchronises and glitch-filters the raw ps2_clk/ps2_data pins, then deserialises 11-bit device-to-host frames.
- Checks odd parity and the stop bit, and pushes valid scancodes into a first-word-fall-through FIFO.
- The AXI slave pops the FIFO on a read of its data register and exposes status and sticky error flags.

Parameters:
FIFO_DEPTH, 8, scancode FIFO entries; power of 2, minimum 2.
FILTER_LEN, 4, ACLK cycles a synchronised ps2_clk level must be stable before the filtered clock changes.
TIMEOUT_CYCLES, 15000, ACLK cycles without a filtered falling edge mid-frame before the frame is aborted (150 us at 100 MHz).

Ports:
ACLK  in  1  system clock; single clock domain.
ARESETN  in  1  reset, synchronous, active-low.
ps2_clk_i  in  1  raw PS/2 clock pin, asynchronous.
ps2_data_i  in  1  raw PS/2 data pin, asynchronous.
rd_en  in  1  pop pulse from AXI register read; ignored when empty.
rd_data  out  8  FIFO head scancode; valid while empty=0.
empty  out  1  FIFO empty; also used as the inverse of the receive interrupt.
full  out  1  FIFO holds FIFO_DEPTH entries.
count  out  clog2(FIFO_DEPTH)+1  number of occupied entries.
err_clr  in  1  pulse; clears parity_err, frame_err and overflow.
parity_err  out  1  sticky: frame received with even parity.
frame_err  out  1  sticky: stop bit was 0, or the frame timed out.
overflow  out  1  sticky: valid frame dropped because the FIFO was full.

Behaviour:
- Reset values: empty=1; full=0; count=0; rd_data=0; all sticky flags=0; FSM=IDLE. Synchronisers and filter reset to 1 (bus idle high).
- Input conditioning:
  - Both pins pass through 2-flop synchronisers.
  - filt_clk changes only after the synchronised clock has held the new level for FILTER_LEN consecutive cycles; shorter pulses are ignored.
  - fall = registered one-cycle pulse on a 1->0 transition of filt_clk.
  - On each fall, the synchronised data bit is sampled.
- FSM (all transitions are taken on fall unless noted):
  - IDLE: sampled 0 -> DATA with bit counter=0. Sampled 1 -> stay in IDLE; no flag is set.
  - DATA: shift right, MSB-in (the first data bit ends in bit 0). After the 8th bit -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP:
    - Stop bit=1 and XOR(data, parity)=1: push data, then -> IDLE.
    - Parity bad: set parity_err, no push, -> IDLE.
    - Stop bit=0: set frame_err, no push, -> IDLE.
    - Both bad: set both flags.
  - Timeout: a counter clears on every fall and runs whenever state != IDLE. When it reaches TIMEOUT_CYCLES: state -> IDLE, partial frame discarded, frame_err set.
- Push timing:
  - The write occurs on the ACLK edge after the fall pulse for the stop bit.
  - empty, count and rd_data reflect the new entry on that same edge.
- FIFO:
  - Circular buffer with read/write pointers and a separate count.
  - FWFT: rd_data always shows the head entry.
  - rd_en with empty=0 advances the read pointer; the new head is visible on the next edge.
- Simultaneous events:
  - Push and pop in the same cycle when full: both succeed, count unchanged, no overflow.
  - Push with full=1 and no pop: data dropped, overflow set.
  - Push and pop in the same cycle when empty: push only; the pop is ignored.
  - err_clr in the same cycle as a new error event: set wins.
- Pointer wrap: the pointers are clog2(FIFO_DEPTH) bits and wrap naturally. full = (count==FIFO_DEPTH).
- Reset mid-frame: the partial frame and all FIFO contents are discarded and all outputs return to reset values. The next valid start bit is received normally.
- No host-to-device transmission. The block never drives the pins.

Test Plan:
- Valid frame 0x1C ('A' make code): start 0, data bits LSB-first 0,0,1,1,1,0,0,0, parity 0, stop 1, 12.5 kHz clock. Required: empty falls, count=1, rd_data=0x1C, no flags set. One rd_en pulse -> empty=1, count=0.
- Parity error: 0x1C sent with parity 1 -> parity_err=1, count stays 0. err_clr pulse -> parity_err=0.
- Overflow and wrap:
  - Send 9 valid frames 0x01..0x09 with no reads -> full=1, count=8, overflow=1.
  - Reading 8 times returns 0x01..0x08 in order.
  - Then send 0xF0 and 0x1C and read both back, proving pointer wrap.
- Timeout recovery: 5 bits of a frame, then the clock idles for 20000 cycles -> frame_err=1, FSM back in IDLE. A subsequent full frame 0xF0 -> rd_data=0xF0, count=1.
- Glitch rejection: a 2-cycle low pulse on ps2_clk_i during IDLE and during DATA -> no bit sampled. A frame of 0x1C around the glitch is still received correctly.
- Simultaneous and reset cases:
  - With count=8, a push coincides with rd_en -> count remains 8, overflow stays 0.
  - ARESETN=0 for one cycle mid-frame -> empty=1, count=0, all flags 0. The next frame 0x29 is received correctly.
